// File: rtl/pacman_pkg.sv
// Shared maze description, score-command encodings and pellet-tracker states.
package pacman_pkg;
  localparam int MAZE_COLS = 24;
  localparam int MAZE_ROWS = 14;
  localparam int START_X   = 11;
  localparam int START_Y   = 6;

  // Row y holds cell x at bit (23 - x); 1 = wall.
  localparam logic [MAZE_COLS-1:0] MAZE_WALL [0:MAZE_ROWS-1] = '{
    24'hFFFFFF, 24'h800001, 24'hBDBDBD, 24'h800001, 24'hBDBDBD, 24'h800001, 24'h800001,
    24'hBDBDBD, 24'h800001, 24'hBDBDBD, 24'h800001, 24'hBDBDBD, 24'h800001, 24'hFFFFFF
  };

  localparam logic [4:0] POWER_X [0:3] = '{5'd1, 5'd22, 5'd1, 5'd22};
  localparam logic [3:0] POWER_Y [0:3] = '{4'd1, 4'd1, 4'd12, 4'd12};

  function automatic int count_pellets();
    int n;
    n = 0;
    for (int r = 0; r < MAZE_ROWS; r++)
      for (int c = 0; c < MAZE_COLS; c++)
        if (!MAZE_WALL[r][c]) n++;
    return n - 1;  // the start cell never holds a pellet
  endfunction

  localparam int PELLET_TOTAL = count_pellets();

  function automatic logic is_power(input logic [4:0] x, input logic [3:0] y);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 4; i++)
      if (POWER_X[i] == x && POWER_Y[i] == y) hit = 1'b1;
    return hit;
  endfunction

  typedef enum logic [1:0] {
    SEL_PELLET = 2'b00,
    SEL_POWER  = 2'b01,
    SEL_GHOST  = 2'b10,
    SEL_DOUBLE = 2'b11
  } score_sel_t;

  typedef enum logic [2:0] {
    ST_INIT, ST_IDLE, ST_CHECK, ST_BONUS, ST_DONE
  } tracker_state_t;
endpackage

// File: rtl/fright_timer.sv
// Frightened-mode countdown: load restarts the full duration, clear aborts it.
module fright_timer #(
  parameter int W      = 29,
  parameter int CYCLES = 300_000_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load,
  input  logic clear,
  output logic active
);
  logic [W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n || clear)  count <= '0;
    else if (load)          count <= W'(CYCLES);
    else if (count != '0)   count <= count - 1'b1;
  end

  assign active = (count != '0);
endmodule

// File: rtl/pellet_tracker.sv
// Live pellet map and event sequencer feeding single-cycle commands to the score ALU.
module pellet_tracker
  import pacman_pkg::*;
#(
  parameter int COLS          = MAZE_COLS,
  parameter int ROWS          = MAZE_ROWS,
  parameter int FRIGHT_W      = 29,          // 300e6 does not fit in 28 bits
  parameter int FRIGHT_CYCLES = 300_000_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [4:0] pac_x,
  input  logic [3:0] pac_y,
  input  logic       pos_valid,
  input  logic       ghost_hit,
  input  logic       level_restart,
  output logic       pos_ready,
  output logic       score_en,
  output logic [1:0] score_sel,
  output logic [8:0] pellets_left,
  output logic       frightened,
  output logic       pac_dead,
  output logic       level_clear
);
  tracker_state_t state_q, state_d;
  logic [3:0]      row_q, row_d;
  logic [4:0]      x_q, x_d;
  logic [3:0]      y_q, y_d;
  logic            pending_q, pending_d;
  logic            score_en_d, pac_dead_d, level_clear_d;
  score_sel_t      score_sel_d;
  logic [8:0]      pellets_d;
  logic            map_init, map_clear, fright_load, fright_clear;
  logic            pos_accept, ghost_serve, pellet_hit;
  logic [4:0]      bit_idx;
  logic [COLS-1:0] init_row;
  logic [COLS-1:0] pellet_row [ROWS];

  assign pos_ready  = (state_q == ST_IDLE) && !pending_q;
  assign pos_accept = pos_valid && pos_ready && (pac_x < 5'(COLS)) && (pac_y < 4'(ROWS));
  assign bit_idx    = 5'(COLS - 1) - x_q;
  assign pellet_hit = pellet_row[y_q][bit_idx];

  always_comb begin
    init_row = ~MAZE_WALL[row_q];
    if (row_q == 4'(START_Y)) init_row[COLS-1-START_X] = 1'b0;
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d       = state_q;
    row_d         = row_q;
    x_d           = x_q;
    y_d           = y_q;
    pending_d     = pending_q;
    pellets_d     = pellets_left;
    level_clear_d = level_clear;
    score_en_d    = 1'b0;
    score_sel_d   = SEL_PELLET;
    pac_dead_d    = 1'b0;
    map_init      = 1'b0;
    map_clear     = 1'b0;
    fright_load   = 1'b0;
    fright_clear  = 1'b0;

    // A ghost event coincident with an accepted move waits until the pellet award is out.
    ghost_serve = (state_q == ST_IDLE) && (pending_q || ghost_hit) && !pos_accept;
    if (ghost_serve) begin
      pending_d = 1'b0;
      if (frightened) begin
        score_en_d  = 1'b1;
        score_sel_d = SEL_GHOST;
      end else begin
        pac_dead_d = 1'b1;
      end
    end else if (ghost_hit && state_q != ST_DONE) begin
      pending_d = 1'b1;
    end

    unique case (state_q)
      ST_INIT: begin
        map_init = 1'b1;
        row_d    = row_q + 4'd1;
        if (row_q == 4'(ROWS - 1)) begin
          row_d     = '0;
          pellets_d = 9'(PELLET_TOTAL);
          state_d   = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (pos_accept) begin
          x_d     = pac_x;
          y_d     = pac_y;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        state_d = ST_IDLE;
        if (pellet_hit) begin
          map_clear   = 1'b1;
          pellets_d   = pellets_left - 9'd1;
          score_en_d  = 1'b1;
          score_sel_d = is_power(x_q, y_q) ? SEL_POWER : SEL_PELLET;
          fright_load = is_power(x_q, y_q);
          if (pellets_left == 9'd1) state_d = ST_BONUS;
        end
      end
      ST_BONUS: begin
        score_en_d    = 1'b1;
        score_sel_d   = SEL_DOUBLE;
        level_clear_d = 1'b1;
        state_d       = ST_DONE;
      end
      ST_DONE: begin
        pending_d = 1'b0;
        if (level_restart) begin
          level_clear_d = 1'b0;
          fright_clear  = 1'b1;
          row_d         = '0;
          state_d       = ST_INIT;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ST_INIT;
      row_q        <= '0;
      x_q          <= '0;
      y_q          <= '0;
      pending_q    <= 1'b0;
      score_en     <= 1'b0;
      score_sel    <= SEL_PELLET;
      pac_dead     <= 1'b0;
      level_clear  <= 1'b0;
      pellets_left <= '0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      x_q          <= x_d;
      y_q          <= y_d;
      pending_q    <= pending_d;
      score_en     <= score_en_d;
      score_sel    <= score_sel_d;
      pac_dead     <= pac_dead_d;
      level_clear  <= level_clear_d;
      pellets_left <= pellets_d;
    end
  end

  // NOTE: the map array has no reset; INIT rewrites every row before any lookup can use it.
  always_ff @(posedge clk) begin
    if (map_init)       pellet_row[row_q]          <= init_row;
    else if (map_clear) pellet_row[y_q][bit_idx]   <= 1'b0;
  end

  fright_timer #(
    .W      (FRIGHT_W),
    .CYCLES (FRIGHT_CYCLES)
  ) u_fright_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (fright_load),
    .clear   (fright_clear),
    .active  (frightened)
  );
endmodule
